bit_stuffer: RTL and testbench
==============================

Name: bit_stuffer

Overview:
Serial USB bit-stuffing stage. It sits directly downstream of the CRC stage and upstream of the NRZI encoder. It passes the CRC stage's serial stream (SYNC, PID, payload, CRC) through unchanged, and inserts a 0 after every STUFF_LEN consecutive 1s. While it inserts that 0 it holds off the CRC stage with `pause`, and it frames the output for the NRZI encoder with start and end strobes.

Parameters:
STUFF_LEN, 6, number of consecutive output 1s that forces an inserted 0 (USB: 6).
CW, $clog2(STUFF_LEN+1), width of the ones counter (derived; not overridden).
SC_W, 8, width of the per-packet stuffed-bit counter.

Ports:
clk  in  1  clock.
rst_n  in  1  reset; asynchronous, active-low.
s_in  in  1  serial bit from the CRC stage; valid in ACTIVE when pause=0 and endr_b=0.
start_b  in  1  one-cycle strobe from the CRC stage; the first bit is presented the following cycle.
endr_b  in  1  one-cycle strobe from the CRC stage; the previous consumed bit was the last one; s_in is invalid this cycle.
pause  out  1  combinational; 1 means the CRC stage must not advance, and s_in is held.
s_out  out  1  registered stuffed bit to the NRZI encoder.
out_valid  out  1  registered; s_out is meaningful this cycle.
start_o  out  1  registered; pulses with the first out_valid bit of a packet.
end_o  out  1  registered; one-cycle pulse after the last out_valid bit of a packet.
stuff_cnt  out  SC_W  number of 0s inserted in the current or last packet; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ones=0, end_pend=0, first=0.
  - s_out, out_valid, start_o and end_o are 0; stuff_cnt=0.
  - pause=0 (it is combinational from state).
- States:
  - IDLE. pause=0; out_valid=0.
    - On start_b: go to ACTIVE, ones<=0, stuff_cnt<=0, first<=1.
    - endr_b in IDLE is ignored.
  - ACTIVE. pause = (ones==STUFF_LEN). Priority, highest first:
    1. start_b: restart. ones<=0, stuff_cnt<=0, first<=1, end_pend<=0. No end_o. out_valid<=0 this cycle.
    2. ones==STUFF_LEN (stuff cycle): s_out<=0, out_valid<=1, ones<=0, stuff_cnt<=stuff_cnt+1 (saturating). If endr_b=1 this cycle, set end_pend<=1. s_in is not consumed.
    3. endr_b=1 or end_pend=1: out_valid<=0, end_o<=1, end_pend<=0, go to IDLE.
    4. Otherwise (consume s_in): s_out<=s_in, out_valid<=1, start_o<=first, first<=0. ones<=s_in ? ones+1 : 0.
- Latency: 1 clock from the consuming edge to s_out. Each stuffed 0 adds exactly 1 clock. end_o follows the final bit by 1 cycle, or by 2 when the final bit forces a stuff.
- The stuffed 0 counts as a 0: the ones run restarts at 0. A run of 2*STUFF_LEN input 1s yields two stuffed 0s.
- Stuffing applies to the SYNC, PID, data and CRC bits alike. A trailing run of STUFF_LEN 1s is still stuffed before end_o.
- pause is asserted for exactly one cycle per stuff and is never asserted in IDLE.
- start_o is never asserted on a stuffed bit. The first bit is always a SYNC 0, so no stuff precedes it.
- Reset mid-packet: everything returns to IDLE and reset values immediately, with no end_o.

Test Plan:
- Baseline: start_b, then SYNC 00000001 followed by PID 10010110 (8 bits). Required: out_valid for 16 consecutive cycles with identical bits, start_o on the first, end_o 1 cycle after the last, pause never 1, stuff_cnt=0.
- Seven 1s: payload 1111111 then endr_b. Required output 1111110 1, pause high exactly once (the cycle after the 6th 1 is consumed), stuff_cnt=1.
- Twelve 1s: 1 x12 then endr_b. Required output 111111 0 111111 0, two pause pulses, stuff_cnt=2; end_o arrives 2 cycles after the last input bit.
- endr_b in the stuff cycle: the last six bits are 1s and endr_b is asserted on the same cycle as pause. Required: the stuffed 0 is emitted, then end_o on the next cycle (end_pend path).
- Alternating 0101... for 64 bits. Required: no pause, stuff_cnt=0. Next, 1 x8 with STUFF_LEN=3. Required: 111 0 111 0 11, stuff_cnt=2.
- Asserting rst_n=0 mid-packet, and issuing start_b mid-packet. Required for the reset: outputs go to 0 asynchronously. Required for the start_b: restart with no end_o, and the next packet gets a fresh start_o and stuff_cnt=0.

Source files
------------

// File: rtl/bit_stuffer.sv
`default_nettype none
// ============================================================================
// Module   : bit_stuffer
// Purpose  : USB serial bit-stuffing stage between the CRC stage and the NRZI
//            encoder. Passes the serial stream through with one clock of
//            latency and inserts a 0 after every STUFF_LEN consecutive output
//            1s, holding off the upstream stage with `pause` while doing so.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            s_in            - serial bit from the CRC stage
//            start_b, endr_b - packet start / end strobes from the CRC stage
//            pause           - combinational hold-off towards the CRC stage
//            s_out,out_valid - registered stuffed bit stream and its qualifier
//            start_o, end_o  - registered packet framing strobes
//            stuff_cnt       - saturating count of 0s inserted in the packet
// Revision : 1.0 - initial release
// ============================================================================
module bit_stuffer #(
  parameter int STUFF_LEN = 6,
  parameter int SC_W      = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_in,
  input  logic            start_b,
  input  logic            endr_b,
  output logic            pause,
  output logic            s_out,
  output logic            out_valid,
  output logic            start_o,
  output logic            end_o,
  output logic [SC_W-1:0] stuff_cnt
);

  // Ones counter width is derived from the run length and never overridden.
  localparam int              CW       = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0]   ONES_MAX = CW'(STUFF_LEN);
  localparam logic [SC_W-1:0] CNT_MAX  = '1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] ones;
  logic          end_pend;   // endr_b arrived during a stuff cycle
  logic          first;      // next consumed bit is the first of the packet

  // A full run of 1s means this cycle emits the stuffed 0 instead of s_in,
  // so the upstream stage must hold its bit.
  assign pause = (state == ACTIVE) && (ones == ONES_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ones      <= '0;
      end_pend  <= 1'b0;
      first     <= 1'b0;
      s_out     <= 1'b0;
      out_valid <= 1'b0;
      start_o   <= 1'b0;
      end_o     <= 1'b0;
      stuff_cnt <= '0;
    end else begin
      start_o <= 1'b0;
      end_o   <= 1'b0;
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (start_b) begin
            state     <= ACTIVE;
            ones      <= '0;
            stuff_cnt <= '0;
            first     <= 1'b1;
            end_pend  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (start_b) begin
            // Restart: abandon the current packet silently.
            ones      <= '0;
            stuff_cnt <= '0;
            first     <= 1'b1;
            end_pend  <= 1'b0;
            out_valid <= 1'b0;
          end else if (ones == ONES_MAX) begin
            // Stuffed 0 restarts the run; s_in stays held upstream.
            s_out     <= 1'b0;
            out_valid <= 1'b1;
            ones      <= '0;
            if (stuff_cnt != CNT_MAX) begin
              stuff_cnt <= stuff_cnt + 1'b1;
            end
            if (endr_b) begin
              end_pend <= 1'b1;
            end
          end else if (endr_b || end_pend) begin
            out_valid <= 1'b0;
            end_o     <= 1'b1;
            end_pend  <= 1'b0;
            state     <= IDLE;
          end else begin
            s_out     <= s_in;
            out_valid <= 1'b1;
            start_o   <= first;
            first     <= 1'b0;
            ones      <= s_in ? ones + 1'b1 : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_stuffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_stuffer
// Purpose  : Scoreboard bench for bit_stuffer. Two instances (run lengths 6
//            and 3) share the stimulus; `sel` chooses which one is driven
//            against its pause and checked. Expected bits come from a simple
//            run-length model of the stuffing rule.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_stuffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_in = 1'b0;
  logic start_b = 1'b0;
  logic endr_b = 1'b0;
  bit   sel = 1'b0;

  logic       pause6, sout6, ov6, st6, en6;
  logic [7:0] cnt6;
  logic       pause3, sout3, ov3, st3, en3;
  logic [2:0] cnt3;

  bit_stuffer #(.STUFF_LEN(6), .SC_W(8)) u6 (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .start_b(start_b), .endr_b(endr_b),
    .pause(pause6), .s_out(sout6), .out_valid(ov6), .start_o(st6),
    .end_o(en6), .stuff_cnt(cnt6)
  );

  bit_stuffer #(.STUFF_LEN(3), .SC_W(3)) u3 (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .start_b(start_b), .endr_b(endr_b),
    .pause(pause3), .s_out(sout3), .out_valid(ov3), .start_o(st3),
    .end_o(en3), .stuff_cnt(cnt3)
  );

  always #5 clk = ~clk;

  logic m_pause, m_sout, m_valid, m_start, m_end;
  int   m_cnt;
  assign m_pause = sel ? pause3 : pause6;
  assign m_sout  = sel ? sout3  : sout6;
  assign m_valid = sel ? ov3    : ov6;
  assign m_start = sel ? st3    : st6;
  assign m_end   = sel ? en3    : en6;
  assign m_cnt   = sel ? int'(cnt3) : int'(cnt6);

  int checks = 0;
  int fails = 0;
  bit exp_bit_q[$];
  bit exp_first_q[$];
  int exp_cnt_q[$];
  bit in_pkt = 1'b0;
  bit prev_valid = 1'b0;
  bit pkt[$];
  bit eb, ef;
  int ec;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid) begin
        checks++;
        if (exp_bit_q.size() == 0) begin
          fails++;
          $display("FAIL extra_bit: out_valid with s_out=%0b, required no output", m_sout);
        end else begin
          eb = exp_bit_q.pop_front();
          ef = exp_first_q.pop_front();
          if (m_sout !== eb) begin
            fails++;
            $display("FAIL s_out: got %0b required %0b at %0t", m_sout, eb, $time);
          end
          checks++;
          if (m_start !== ef) begin
            fails++;
            $display("FAIL start_o: got %0b required %0b at %0t", m_start, ef, $time);
          end
        end
      end else if (m_start) begin
        checks++;
        fails++;
        $display("FAIL start_o_no_valid: got 1 required 0 at %0t", $time);
      end
      if (m_end) begin
        checks++;
        if (!prev_valid) begin
          fails++;
          $display("FAIL end_timing: prior out_valid 0 required 1 at %0t", $time);
        end
        checks++;
        if (exp_cnt_q.size() == 0) begin
          fails++;
          $display("FAIL extra_end_o: got end_o required none at %0t", $time);
        end else begin
          ec = exp_cnt_q.pop_front();
          if (m_cnt != ec) begin
            fails++;
            $display("FAIL stuff_cnt: got %0d required %0d", m_cnt, ec);
          end
          checks++;
          if (exp_bit_q.size() != 0) begin
            fails++;
            $display("FAIL end_early: %0d bits outstanding required 0", exp_bit_q.size());
          end
        end
      end
      if (m_pause && !in_pkt) begin
        checks++;
        fails++;
        $display("FAIL pause_idle: got 1 required 0 at %0t", $time);
      end
      prev_valid = m_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic add_bits(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) pkt.push_back(v[k]);
  endtask

  task automatic add_ones(input int n);
    for (int k = 0; k < n; k++) pkt.push_back(1'b1);
  endtask

  // Sends pkt (or its first abort_after bits, then leaves the packet open so
  // the next send restarts it). Caller must be at a falling edge.
  task automatic send(input int abort_after);
    int n, i, pc, run, stuffs, len, cap;
    bit last_stuff, ab;
    bit q[$];
    len = sel ? 3 : 6;
    cap = sel ? 7 : 255;
    ab = (abort_after >= 0);
    n = ab ? abort_after : pkt.size();
    run = 0; stuffs = 0; last_stuff = 1'b0;
    for (int k = 0; k < n; k++) begin
      q.push_back(pkt[k]);
      last_stuff = 1'b0;
      run = pkt[k] ? run + 1 : 0;
      if (run == len) begin
        q.push_back(1'b0);
        stuffs++;
        run = 0;
        last_stuff = 1'b1;
      end
    end
    // A stuff still pending when the restart arrives is never emitted.
    if (ab && last_stuff) void'(q.pop_back());
    foreach (q[k]) begin
      exp_bit_q.push_back(q[k]);
      exp_first_q.push_back(k == 0);
    end
    if (!ab) exp_cnt_q.push_back(stuffs > cap ? cap : stuffs);

    in_pkt = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    i = 0; pc = 0;
    while (i < n) begin
      s_in = pkt[i];
      if (m_pause) pc++;
      else i++;
      @(negedge clk);
    end
    if (!ab) begin
      endr_b = 1'b1;
      if (m_pause) pc++;
      @(negedge clk);
      endr_b = 1'b0;
      s_in = 1'b0;
      checks++;
      if (pc != stuffs) begin
        fails++;
        $display("FAIL pause_count: got %0d required %0d", pc, stuffs);
      end
      for (int k = 0; k < 20 && exp_cnt_q.size() != 0; k++) @(negedge clk);
      checks++;
      if (exp_cnt_q.size() != 0) begin
        fails++;
        $display("FAIL end_timeout: end_o not seen, required within 20 cycles");
        exp_cnt_q.delete(); exp_bit_q.delete(); exp_first_q.delete();
      end
      in_pkt = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic chk_zero(input string nm, input logic v);
    checks++;
    if (v !== 1'b0) begin
      fails++;
      $display("FAIL %s: got %0b required 0", nm, v);
    end
  endtask

  task automatic do_reset_check();
    #2 rst_n = 1'b0;
    #1;
    chk_zero("rst_s_out", m_sout);
    chk_zero("rst_out_valid", m_valid);
    chk_zero("rst_start_o", m_start);
    chk_zero("rst_end_o", m_end);
    chk_zero("rst_pause", m_pause);
    checks++;
    if (m_cnt != 0) begin
      fails++;
      $display("FAIL rst_stuff_cnt: got %0d required 0", m_cnt);
    end
    exp_bit_q.delete(); exp_first_q.delete(); exp_cnt_q.delete();
    in_pkt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    #1 do_reset_check();

    // Baseline SYNC + PID.
    pkt.delete(); add_bits(64'h0196, 16); send(-1);
    // Seven 1s, twelve 1s.
    pkt.delete(); add_ones(7);  send(-1);
    pkt.delete(); add_ones(12); send(-1);
    // Trailing six 1s: endr_b lands on the pause cycle.
    pkt.delete(); add_bits(64'h3F, 8); send(-1);
    // Alternating 64 bits.
    pkt.delete(); add_bits(64'h5555_5555_5555_5555, 64); send(-1);
    // Restart with a stuff pending, then restart mid-run, then a clean packet.
    pkt.delete(); add_ones(6); send(6);
    pkt.delete(); add_bits(64'h0117, 16); send(9);
    pkt.delete(); add_bits(64'h0196, 16); send(-1);

    // Randomised packets.
    for (int p = 0; p < 30; p++) begin
      int len, ab;
      pkt.delete();
      add_bits(64'h01, 8);
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) pkt.push_back($urandom_range(0, 3) != 0);
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, pkt.size())) : -1;
      send(ab);
    end

    // Reset in the middle of a packet, after a stuff has happened.
    pkt.delete(); add_ones(7); send(7);
    do_reset_check();
    pkt.delete(); add_bits(64'h0196, 16); send(-1);

    // Short run length instance, including counter saturation.
    sel = 1'b1;
    pkt.delete(); add_ones(8);  send(-1);
    pkt.delete(); add_ones(30); send(-1);
    for (int p = 0; p < 8; p++) begin
      int len;
      pkt.delete();
      add_bits(64'h01, 8);
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) pkt.push_back($urandom_range(0, 2) != 0);
      send(-1);
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp_bit_q.size() != 0 || exp_cnt_q.size() != 0) begin
      fails++;
      $display("FAIL leftover: %0d bits %0d ends outstanding required 0", exp_bit_q.size(), exp_cnt_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
